// File: rtl/reset_handshake_ctrl_if.sv
// Reset handshake bundle between a domain's reset sequencer and its users.
// Signals: sw_rst_req, peer_rst_in (to ctrl); peer_rst_out, reset, busy, peer_timeout (from ctrl).
interface reset_handshake_ctrl_if;
  logic sw_rst_req;
  logic peer_rst_in;
  logic peer_rst_out;
  logic reset;
  logic busy;
  logic peer_timeout;

  modport master (
    output sw_rst_req,
    output peer_rst_in,
    input  peer_rst_out,
    input  reset,
    input  busy,
    input  peer_timeout
  );

  modport slave (
    input  sw_rst_req,
    input  peer_rst_in,
    output peer_rst_out,
    output reset,
    output busy,
    output peer_timeout
  );
endinterface

// File: rtl/reset_handshake_ctrl.sv
// Per-domain reset sequencer: REQ -> HOLD -> REL -> IDLE handshake with a peer.
// Ports: clk, async_rst (async, active-high), bus (slave: sw_rst_req, peer_rst_in -> peer_rst_out, reset, busy, peer_timeout).
module reset_handshake_ctrl #(
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int SYNC_STAGES    = 2
) (
  input logic                  clk,
  input logic                  async_rst,
  reset_handshake_ctrl_if.slave bus
);

  localparam int MAXC = (HOLD_CYCLES > TIMEOUT_CYCLES) ?
                        HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    REL  = 2'd3
  } state_t;

  logic [1:0]             rst_sync;
  logic                   rst_l;
  logic [SYNC_STAGES-1:0] psync;
  logic                   peer_sync;

  state_t       state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic         to_q, to_n;
  logic         reset_q, reset_n;
  logic         prst_q, prst_n;
  logic         busy_q, busy_n;

  // Assert immediately, release two clk edges later.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) rst_sync <= 2'b11;
    else           rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_l = rst_sync[1];

  // Preset to 1: a freshly reset domain assumes the peer is in reset too.
  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) psync <= '1;
    else       psync <= {psync[SYNC_STAGES-2:0], bus.peer_rst_in};
  end

  assign peer_sync = psync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      state_q <= REQ;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      reset_q <= 1'b1;
      prst_q  <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      to_q    <= to_n;
      reset_q <= reset_n;
      prst_q  <= prst_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    to_n    = to_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.sw_rst_req || peer_sync) begin
          state_n = REQ;
          cnt_n   = '0;
        end
      end
      (state_q == REQ): begin
        if (peer_sync) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else if (cnt_q == TO_MAX) begin
          to_n    = 1'b1;
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      (state_q == HOLD): begin
        if (cnt_q == '0) begin
          state_n = REL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      (state_q == REL): begin
        if (!peer_sync) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt_q == TO_MAX) begin
          to_n    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = REQ;
        cnt_n   = '0;
      end
    endcase
  end

  // Decoded from next state so every output comes straight off a flop.
  always_comb begin
    reset_n = (state_n != IDLE);
    busy_n  = (state_n != IDLE);
    prst_n  = (state_n == REQ) || (state_n == HOLD);
  end

  assign bus.reset        = reset_q;
  assign bus.peer_rst_out = prst_q;
  assign bus.busy         = busy_q;
  assign bus.peer_timeout = to_q;

endmodule
